seq_detector_param: RTL

- Clocked, parametrised symbol-sequence detector for switch-panel inputs.
- A W-bit input symbol steps a Moore state machine each time its value changes. The sequence armed by IDLE_SYM followed by N programmable pattern symbols asserts match; the default is the 00->10->11 detector.
- Runtime-loadable pattern, selectable mismatch policy (lockout or re-arm).
- Sits between a synchronised switch bank and LED/status outputs.

---
 rtl/seq_det_pkg.sv | 19 +
 rtl/seq_det_step.sv | 30 +++
 rtl/seq_detector_param.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants, state type and index-width helper for the symbol-sequence detector.
package seq_det_pkg;

  localparam int SEQ_MODE_LOCKOUT = 0;
  localparam int SEQ_MODE_REARM   = 1;

  typedef enum logic [1:0] {
    ST_ARMED,
    ST_PROG,
    ST_MATCH,
    ST_LOCK
  } seq_state_e;

  // Width of the progress index, which must hold values 0..n.
  function automatic int seq_idx_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_det_step.sv
// Tracks the last accepted symbol and flags a step when a valid symbol differs from it.
module seq_det_step
  import seq_det_pkg::*;
#(
  parameter int             W        = 2,
  parameter logic [W-1:0]   IDLE_SYM = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sym_in,
  input  logic         sym_vld,
  output logic         step,
  output logic [W-1:0] step_sym
);

  logic [W-1:0] last_sym;

  assign step     = sym_vld && (sym_in != last_sym);
  assign step_sym = sym_in;

  // last_sym follows every step, even one that a pattern load discards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_sym <= IDLE_SYM;
    end else if (step) begin
      last_sym <= sym_in;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Moore detector: IDLE_SYM then N programmable symbols asserts match.
// Optional saturating match counter enabled by defining SEQ_DET_MATCH_CNT_EN.
//
// state | meaning
// ARMED | idle symbol seen (or reset/load), progress index 0
// PROG  | partway through the pattern, index 1..N-1
// MATCH | full pattern seen, index N, match=1
// LOCK  | mismatch under lockout policy, index 0, locked=1 until IDLE_SYM
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int             W           = 2,
  parameter int             N           = 2,
  parameter int             MODE        = SEQ_MODE_LOCKOUT,
  parameter logic [W-1:0]   IDLE_SYM    = '0,
  parameter logic [N*W-1:0] PAT_DEFAULT = 4'b1110,
  parameter int             CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [W-1:0]              sym_in,
  input  logic                      sym_vld,
  input  logic [N*W-1:0]            pat_in,
  input  logic                      pat_load,
  output logic                      match,
  output logic                      locked,
  output logic [seq_idx_w(N)-1:0]   state_idx
`ifdef SEQ_DET_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]          match_cnt
`endif
);

  localparam int            IW      = seq_idx_w(N);
  localparam logic [IW-1:0] IDX_N   = IW'(N);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  logic           step;
  logic [W-1:0]   step_sym;
  seq_state_e     st_q, st_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N*W-1:0] pat_q;
  logic [W-1:0]   exp_sym;
  logic           enter_match;

  seq_det_step #(
    .W        (W),
    .IDLE_SYM (IDLE_SYM)
  ) u_step (
    .clk      (clk),
    .rst_n    (rst_n),
    .sym_in   (sym_in),
    .sym_vld  (sym_vld),
    .step     (step),
    .step_sym (step_sym)
  );

  always_comb begin
    exp_sym = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IW'(k)) exp_sym = pat_q[k*W +: W];
    end
  end

  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    if (pat_load) begin
      st_d  = ST_ARMED;
      idx_d = '0;
    end else if (step) begin
      if (step_sym == IDLE_SYM) begin
        st_d  = ST_ARMED;
        idx_d = '0;
      end else if (st_q == ST_LOCK) begin
        st_d  = ST_LOCK;
      end else if ((idx_q < IDX_N) && (step_sym == exp_sym)) begin
        idx_d = idx_q + IDX_ONE;
        st_d  = (idx_q + IDX_ONE == IDX_N) ? ST_MATCH : ST_PROG;
      end else if (MODE == SEQ_MODE_REARM && step_sym == pat_q[W-1:0]) begin
        // Re-arm only looks at the first pattern symbol; no deeper overlap search.
        idx_d = IDX_ONE;
        st_d  = (IDX_ONE == IDX_N) ? ST_MATCH : ST_PROG;
      end else if (MODE == SEQ_MODE_REARM) begin
        st_d  = ST_ARMED;
        idx_d = '0;
      end else begin
        st_d  = ST_LOCK;
        idx_d = '0;
      end
    end
  end

  assign enter_match = (st_d == ST_MATCH) && (st_q != ST_MATCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= ST_ARMED;
      idx_q <= '0;
      pat_q <= PAT_DEFAULT;
    end else begin
      st_q  <= st_d;
      idx_q <= idx_d;
      if (pat_load) pat_q <= pat_in;
    end
  end

  assign match     = (st_q == ST_MATCH);
  assign locked    = (st_q == ST_LOCK);
  assign state_idx = idx_q;

`ifdef SEQ_DET_MATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (pat_load) begin
      match_cnt <= '0;
    end else if (enter_match && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = enter_match ^ (CNT_W[0]);
`endif

endmodule
